// File: rtl/per_capture_pkg.sv
// per_pkg: shared widths, limits and FSM state type for the period-capture slice
package per_pkg;
  localparam int PER_W = 9;
  localparam logic [PER_W-1:0] PER_MAX = 9'h1FF;
  typedef enum logic [1:0] {WAIT_FIRST, MEAS, OVF} per_state_t;
endpackage

// File: rtl/per_capture_if.sv
// per_capture_if: measured signal, counter link and consumer handshake of per_capture
interface per_capture_if;
  import per_pkg::*;
  logic sig_in;
  logic [PER_W-1:0] period;
  logic rd;
  logic clr_period;
  logic [PER_W-1:0] per_val;
  logic per_rdy;
  logic ovfl;
  modport master(output sig_in, period, rd, input clr_period, per_val, per_rdy, ovfl);
  modport slave(input sig_in, period, rd, output clr_period, per_val, per_rdy, ovfl);
endinterface

// File: rtl/per_capture_edge_sync.sv
// edge_sync: multi-flop synchronizer plus history flop producing a one-cycle rise pulse
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic [STAGES-1:0] sync;
  logic hist;
  // vld marks how far genuine samples have travelled since reset, so the reset
  // zeros in the chain are never mistaken for a low level preceding a rise
  logic [STAGES:0] vld;
  // shift the input through the synchronizer and remember the previous output
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
      vld  <= '0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      hist <= sync[STAGES-1];
      vld  <= {vld[STAGES-1:0], 1'b1};
    end
  assign rise = sync[STAGES-1] & ~hist & vld[STAGES];
endmodule

// File: rtl/per_capture.sv
// per_capture: edge-driven period capture FSM with ready/ack handshake and overflow flag
module per_capture
  import per_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  per_capture_if.slave bus
);
  per_state_t state;
  logic rise;
  logic [PER_W-1:0] per_val;
  logic per_rdy;
  logic ovfl;
  edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.sig_in),
    .rise(rise)
  );
  // the counter is held cleared unless a measurement is running, and restarts on every edge
  always_comb bus.clr_period = (state != MEAS) | rise;
  assign bus.per_val = per_val;
  assign bus.per_rdy = per_rdy;
  assign bus.ovfl    = ovfl;
  // FSM plus capture/handshake registers; a capture after the rd clear wins on the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= WAIT_FIRST;
      per_val <= '0;
      per_rdy <= 1'b0;
      ovfl    <= 1'b0;
    end else begin
      if (bus.rd) per_rdy <= 1'b0;
      case (state)
        WAIT_FIRST: if (rise) state <= MEAS;
        MEAS:
          if (rise && bus.period != PER_MAX) begin
            per_val <= bus.period + 9'd1;
            per_rdy <= 1'b1;
            ovfl    <= 1'b0;
          end else if (rise) ovfl <= 1'b1;
          else if (bus.period == PER_MAX) begin
            state <= OVF;
            ovfl  <= 1'b1;
          end
        OVF: if (rise) state <= MEAS;
        default: state <= WAIT_FIRST;
      endcase
    end
endmodule

// File: tb/tb_per_capture.sv
// tb_per_capture: randomized period stimulus against an interval-level reference model
module tb_per_capture;
  import per_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [PER_W-1:0] cnt;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cnt = 0;
  per_state_t m_state = WAIT_FIRST;
  int m_val = 0;
  int m_rdy = 0;
  int m_ovfl = 0;
  int last_t = 0;
  per_capture_if bus();
  per_capture #(.SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (dut.rise) rise_cnt <= rise_cnt + 1;
  // behavioural per_cnt: synchronous clear, otherwise free-running 9-bit count
  always @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= bus.clr_period ? '0 : cnt + 9'd1;
  assign bus.period = cnt;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // one synchronized rising edge closing an interval of n cycles
  task automatic model_edge(input int n);
    if (m_state != MEAS) m_state = MEAS;
    else if (n <= 511) begin
      m_val = n;
      m_rdy = 1;
      m_ovfl = 0;
    end else m_ovfl = 1;
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".per_val"}, 32'(bus.per_val), 32'(m_val));
    chk({tag, ".per_rdy"}, 32'(bus.per_rdy), 32'(m_rdy));
    chk({tag, ".ovfl"}, 32'(bus.ovfl), 32'(m_ovfl));
    chk({tag, ".state"}, 32'(dut.state), 32'(m_state));
    chk({tag, ".clr"}, 32'(bus.clr_period), 32'(m_state != MEAS));
  endtask
  // drive one period of n cycles starting with a rising edge; rd pulses in cycle rk (-1: none)
  task automatic run_period(input int n, input int rk, input string tag);
    int t0;
    t0 = cyc;
    if (rk >= 0 && rk <= 2) m_rdy = 0;
    model_edge(t0 - last_t);
    last_t = t0;
    if (rk > 2) m_rdy = 0;
    for (int k = 0; k < n; k++) begin
      bus.sig_in = (k < n / 2);
      bus.rd = (k == rk);
      @(negedge clk);
    end
    bus.rd = 1'b0;
    if (m_state == MEAS && n >= 520) begin
      m_state = OVF;
      m_ovfl = 1;
    end
    check_all(tag);
  endtask
  initial begin
    int n, r;
    bus.sig_in = 1'b1;
    bus.rd = 1'b0;
    #1;
    chk("rst.clr", 32'(bus.clr_period), 1);
    chk("rst.per_val", 32'(bus.per_val), 0);
    chk("rst.per_rdy", 32'(bus.per_rdy), 0);
    chk("rst.ovfl", 32'(bus.ovfl), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("hold_high.rise", 32'(rise_cnt), 0);
    check_all("hold_high");
    bus.sig_in = 1'b0;
    repeat (5) @(negedge clk);
    run_period(20, -1, "sq20_first");
    run_period(20, -1, "sq20_cap");
    run_period(20, 19, "sq20_rd");
    run_period(511, -1, "p511_start");
    run_period(512, -1, "p511_cap");
    run_period(600, -1, "p512_ovf");
    run_period(10, -1, "p600_ovf");
    run_period(10, -1, "after_ovf");
    run_period(10, -1, "p10_cap");
    run_period(30, -1, "p30_start");
    run_period(40, -1, "p30_cap");
    run_period(25, 2, "p40_rd_same");
    for (int i = 0; i < 40; i++) begin
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(520, 700) : $urandom_range(4, 300);
      r = $urandom_range(0, 2);
      run_period(n, (r == 0) ? -1 : (r == 1) ? 2 : n - 1, $sformatf("rand%0d", i));
    end
    run_period(25, -1, "pre_rst_a");
    run_period(25, -1, "pre_rst_b");
    model_edge(cyc - last_t);
    last_t = cyc;
    for (int k = 0; k < 7; k++) begin
      bus.sig_in = (k < 3);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    m_state = WAIT_FIRST;
    m_val = 0;
    m_rdy = 0;
    m_ovfl = 0;
    check_all("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_period(15, -1, "post_rst_first");
    run_period(15, -1, "post_rst_cap");
    run_period(15, -1, "post_rst_cap2");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/per_capture.md
# per_capture

Period-capture controller that sits directly upstream of the `per_cnt` period counter. It synchronizes an asynchronous measured signal and detects its rising edges. It drives `clr_period` to restart the counter on each edge and latches the finished count as a measured period in clock cycles. It presents that value to a downstream consumer through a ready/acknowledge handshake and flags measurements that exceed the 9-bit range.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops on `sig_in`; legal range is 2 or more.
- `clk`  in  1  system clock; every flop is rising-edge triggered.
- `rst`  in  1  reset; asynchronous, active-high.
- `sig_in`  in  1  asynchronous signal whose period is measured.
- `period`  in  9  current count from `per_cnt`.
- `rd`  in  1  consumer acknowledge; a one-cycle pulse consumes `per_val`.
- `clr_period`  out  1  synchronous clear driven to `per_cnt`; combinational from state and `rise`.
- `per_val`  out  9  last captured period, in clk cycles between synchronized rising edges.
- `per_rdy`  out  1  `per_val` holds an unconsumed capture.
- `ovfl`  out  1  sticky flag: a period exceeded `9'h1FF`.

## Operation
- **Synchronizer**
  - `SYNC_STAGES` flops plus one history flop, all reset to 0.
  - `rise = sync_out & ~hist`.
  - `sig_in` held high through reset release produces no `rise`.
- **FSM states:** WAIT_FIRST (reset state), MEAS, OVF.
- **WAIT_FIRST**
  - `clr_period = 1` continuously.
  - On `rise`, go to MEAS.
- **MEAS**
  - `clr_period = rise`, so the counter reads 0 on the cycle after an edge.
  - On `rise` with `period <= 9'h1FE`: `per_val <= period + 1`, `per_rdy <= 1`, `ovfl <= 0`; stay in MEAS.
  - With no `rise` and `period == 9'h1FF`: go to OVF and set `ovfl <= 1`.
  - With `rise` and `period == 9'h1FF` on the same cycle: no capture, `ovfl <= 1`, `clr_period = 1`, stay in MEAS. The edge starts a new measurement.
- **OVF**
  - `clr_period = 1` continuously.
  - On `rise`, go to MEAS without a capture.
- **Width rule:** the captured value never exceeds `9'h1FF`, and all arithmetic is 9-bit. The overflow rules above prevent `9'h200` from ever being formed into `per_val`.
- **Handshake**
  - `rd` with `per_rdy = 1` clears `per_rdy` on the next edge.
  - `rd` with `per_rdy = 0` is ignored.
  - A capture and `rd` on the same cycle: the capture wins, `per_val` updates and `per_rdy` stays 1.
  - A capture while `per_rdy = 1` overwrites `per_val`; there is no queueing.
- **`ovfl`**
  - Cleared only by a successful capture or by reset.
  - Unaffected by `rd`.
- **Reset values:** state WAIT_FIRST, `per_val = 9'h000`, `per_rdy = 0`, `ovfl = 0`, synchronizer and history flops 0. `clr_period` is therefore 1 during reset.

## Timing
- `rise` asserts for exactly one cycle, `SYNC_STAGES` clock edges after the edge at which `sig_in` high is first sampled.
- Counter alignment:
  - `clr_period` is high in edge cycle t.
  - `per_cnt` reads 0 at t+1.
  - At the next edge cycle t+N it reads N-1, so the captured value is N.
- `per_val` and `per_rdy` update on the clock edge that ends the `rise` cycle. Latency from `rise` to `per_rdy` is 1 cycle.
- Maximum representable period is 511 cycles. A period of 512 or more sets `ovfl`.
- Asserting `rst` mid-measurement forces all reset values immediately, with no clock needed. Measurement restarts from WAIT_FIRST after release.

## Structure
- Shared package `per_pkg`:
  - `PER_W = 9`.
  - `PER_MAX = 9'h1FF`.
  - `typedef enum logic [1:0] {WAIT_FIRST, MEAS, OVF} per_state_t`.
- One sub-module, `edge_sync`: parameterized synchronizer plus history flop with a `rise` output, reusable by other edge-driven blocks.
- `per_capture` holds the FSM and the capture/handshake registers. It does not instantiate `per_cnt`; the integration level connects `clr_period` and `period`.

## Test plan
- Reset with `sig_in = 1`, then hold it high for 50 cycles → `rise` never fires, state stays WAIT_FIRST, `clr_period = 1`, `per_rdy = 0`, `per_val = 9'h000`.
- Square wave with a 20-cycle period → after the second edge `per_val = 9'h014` and `per_rdy = 1`. A `rd` pulse then gives `per_rdy = 0` next cycle with `per_val` held.
- Edges 511 cycles apart → `per_val = 9'h1FF`, `ovfl = 0`. Edges 512 apart → no capture, `ovfl = 1`, measurement restarts on that edge.
- Edges 600 cycles apart, then 10 apart → `ovfl = 1` and state OVF once `period` reaches `9'h1FF`. The first edge after that gives no capture. The following 10-cycle interval gives `per_val = 9'h00A`, `per_rdy = 1`, `ovfl = 0`.
- Periods 30 then 40 without `rd` → `per_val = 9'h028`, `per_rdy = 1`. A `rd` on the same cycle as the 40 capture → `per_rdy` remains 1.
- Assert `rst` 7 cycles into a measurement, between clock edges → outputs take reset values before the next `clk` edge. After release, the next period is measured correctly from the first new edge.
